// File: rtl/gemips_ctrl_pkg.sv
// Shared encodings for the GeMIPS pipeline stall/bubble control.
package gemips_ctrl_pkg;

    localparam int unsigned STALL_W = 5;
    localparam int unsigned PERF_W  = 32;

    localparam int unsigned STALL_PC    = 0;
    localparam int unsigned STALL_IFID  = 1;
    localparam int unsigned STALL_IDEX  = 2;
    localparam int unsigned STALL_EXMEM = 3;
    localparam int unsigned STALL_MEMWB = 4;

    localparam logic [STALL_W-1:0] STALL_NONE = 5'b00000;
    localparam logic [STALL_W-1:0] STALL_LOAD = 5'b00011;
    localparam logic [STALL_W-1:0] STALL_MUL  = 5'b00111;
    localparam logic [STALL_W-1:0] STALL_MEMC = 5'b00001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MUL  = 2'd2,
        ST_MEMC = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ACT_NONE = 2'd0,
        ACT_LOAD = 2'd1,
        ACT_MUL  = 2'd2,
        ACT_MEM  = 2'd3
    } act_e;

    typedef struct packed {
        logic [STALL_W-1:0] stall;
        logic               bubble_ex;
        logic               bubble_mem;
        logic               flush_if;
    } ctrl_t;

    // Pipeline-register controls produced by one action.
    function automatic ctrl_t act_ctrl(act_e act);
        ctrl_t c;
        c = '0;
        unique case (act)
            ACT_LOAD: begin c.stall = STALL_LOAD; c.bubble_ex  = 1'b1; end
            ACT_MUL:  begin c.stall = STALL_MUL;  c.bubble_mem = 1'b1; end
            ACT_MEM:  begin c.stall = STALL_MEMC; c.flush_if   = 1'b1; end
            default:  c.stall = STALL_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard request / pipeline control bundle between the stages and pipe_ctrl.
interface pipe_ctrl_if;
    import gemips_ctrl_pkg::*;

    logic               id_req;
    logic               ex_mul_start;
    logic               mem_req;
    logic               mem_base_hit;
    logic [STALL_W-1:0] stall;
    logic               bubble_ex;
    logic               bubble_mem;
    logic               flush_if;
    logic               busy;
    logic [PERF_W-1:0]  perf_stall_cyc;
    logic [PERF_W-1:0]  perf_mul_cyc;

    modport master (
        output id_req, ex_mul_start, mem_req, mem_base_hit,
        input  stall, bubble_ex, bubble_mem, flush_if, busy,
        input  perf_stall_cyc, perf_mul_cyc
    );

    modport slave (
        input  id_req, ex_mul_start, mem_req, mem_base_hit,
        output stall, bubble_ex, bubble_mem, flush_if, busy,
        output perf_stall_cyc, perf_mul_cyc
    );
endinterface

// File: rtl/stall_timer.sv
// Down-counter shared by the multi-cycle stall states; zero marks the last cycle.
module stall_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// GeMIPS stall/bubble sequencer. Optional perf counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import gemips_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYC = 1,
    parameter int unsigned MUL_LAT        = 3,
    parameter int unsigned MEM_LAT        = 1,
    parameter int unsigned CNT_W          = 4
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    // Timer preload is L-2: the request cycle is spent in IDLE, the last one at zero.
    localparam logic [CNT_W-1:0] LOAD_TV = CNT_W'((LOAD_STALL_CYC > 1) ? LOAD_STALL_CYC - 2 : 0);
    localparam logic [CNT_W-1:0] MUL_TV  = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
    localparam logic [CNT_W-1:0] MEM_TV  = CNT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

    state_e           state, state_nxt;
    act_e             act;
    ctrl_t            ctrl;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    stall_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_val),
        .dec   (tmr_dec),
        .zero  (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // IDLE arbitrates requests (Mealy); wait states replay their action until the timer expires.
    always_comb begin
        state_nxt = state;
        act       = ACT_NONE;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_dec   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.ex_mul_start) begin
                    act = ACT_MUL;
                    if (MUL_LAT > 1) begin
                        state_nxt = ST_MUL;
                        tmr_load  = 1'b1;
                        tmr_val   = MUL_TV;
                    end
                end else if (bus.mem_req && bus.mem_base_hit) begin
                    act = ACT_MEM;
                    if (MEM_LAT > 1) begin
                        state_nxt = ST_MEMC;
                        tmr_load  = 1'b1;
                        tmr_val   = MEM_TV;
                    end
                end else if (bus.id_req) begin
                    act = ACT_LOAD;
                    if (LOAD_STALL_CYC > 1) begin
                        state_nxt = ST_LOAD;
                        tmr_load  = 1'b1;
                        tmr_val   = LOAD_TV;
                    end
                end
            end
            ST_LOAD: act = ACT_LOAD;
            ST_MUL:  act = ACT_MUL;
            ST_MEMC: act = ACT_MEM;
            default: state_nxt = ST_IDLE;
        endcase
        if (state != ST_IDLE) begin
            if (tmr_zero) state_nxt = ST_IDLE;
            else          tmr_dec   = 1'b1;
        end
    end

    assign ctrl           = rst ? '0 : act_ctrl(act);
    assign bus.stall      = ctrl.stall;
    assign bus.bubble_ex  = ctrl.bubble_ex;
    assign bus.bubble_mem = ctrl.bubble_mem;
    assign bus.flush_if   = ctrl.flush_if;
    assign bus.busy       = !rst && (state != ST_IDLE);

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] perf_stall_q, perf_mul_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_mul_q   <= '0;
        end else begin
            if (ctrl.stall != STALL_NONE) perf_stall_q <= perf_stall_q + PERF_W'(1);
            if (act == ACT_MUL)           perf_mul_q   <= perf_mul_q + PERF_W'(1);
        end
    end

    assign bus.perf_stall_cyc = perf_stall_q;
    assign bus.perf_mul_cyc   = perf_mul_q;
`else
    assign bus.perf_stall_cyc = '0;
    assign bus.perf_mul_cyc   = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: two parameterisations against an event-count model.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if if0();
    pipe_ctrl_if if1();

    pipe_ctrl #(.LOAD_STALL_CYC(1), .MUL_LAT(3), .MEM_LAT(1), .CNT_W(4)) u0 (
        .clk(clk), .rst(rst), .bus(if0)
    );
    pipe_ctrl #(.LOAD_STALL_CYC(3), .MUL_LAT(5), .MEM_LAT(2), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .bus(if1)
    );

    // Model: an event occupies L cycles; rem counts cycles still owed after the current one.
    int lat_load [2] = '{1, 3};
    int lat_mul  [2] = '{3, 5};
    int lat_mem  [2] = '{1, 2};
    int rem      [2] = '{0, 0};
    int cur      [2] = '{0, 0};   // 0 none, 1 load, 2 mul, 3 mem
    int unsigned pst [2] = '{0, 0};
    int unsigned pmu [2] = '{0, 0};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input int k,
                              input logic [4:0] st, input logic bex, input logic bmem,
                              input logic fl, input logic by,
                              input logic [31:0] ps, input logic [31:0] pm,
                              input logic r, input logic id, input logic mul,
                              input logic mreq, input logic hit);
        int win, a, lat;
        logic [4:0] exp_st;
        win = mul ? 2 : (mreq && hit) ? 3 : id ? 1 : 0;
        a   = r ? 0 : (rem[k] > 0) ? cur[k] : win;
        exp_st = (a == 2) ? 5'b00111 : (a == 3) ? 5'b00001 : (a == 1) ? 5'b00011 : 5'b00000;

        chk($sformatf("u%0d.stall", k),      32'(st),   32'(exp_st));
        chk($sformatf("u%0d.bubble_ex", k),  32'(bex),  32'(a == 1));
        chk($sformatf("u%0d.bubble_mem", k), 32'(bmem), 32'(a == 2));
        chk($sformatf("u%0d.flush_if", k),   32'(fl),   32'(a == 3));
        chk($sformatf("u%0d.busy", k),       32'(by),   32'(!r && rem[k] > 0));
`ifdef PIPE_CTRL_PERF_EN
        chk($sformatf("u%0d.perf_stall", k), ps, pst[k]);
        chk($sformatf("u%0d.perf_mul", k),   pm, pmu[k]);
`else
        chk($sformatf("u%0d.perf_stall", k), ps, 32'd0);
        chk($sformatf("u%0d.perf_mul", k),   pm, 32'd0);
`endif

        // Advance the model across the coming clock edge.
        if (r) begin
            rem[k] = 0; cur[k] = 0; pst[k] = 0; pmu[k] = 0;
        end else begin
            if (a != 0) pst[k]++;
            if (a == 2) pmu[k]++;
            if (rem[k] > 0) begin
                rem[k]--;
            end else if (win != 0) begin
                lat    = (win == 2) ? lat_mul[k] : (win == 3) ? lat_mem[k] : lat_load[k];
                cur[k] = win;
                rem[k] = lat - 1;
            end
        end
    endtask

    task automatic step(input logic r, input logic id, input logic mul,
                        input logic mreq, input logic hit);
        rst = r;
        if0.id_req = id; if0.ex_mul_start = mul; if0.mem_req = mreq; if0.mem_base_hit = hit;
        if1.id_req = id; if1.ex_mul_start = mul; if1.mem_req = mreq; if1.mem_base_hit = hit;
        #1;
        check_inst(0, if0.stall, if0.bubble_ex, if0.bubble_mem, if0.flush_if, if0.busy,
                   if0.perf_stall_cyc, if0.perf_mul_cyc, r, id, mul, mreq, hit);
        check_inst(1, if1.stall, if1.bubble_ex, if1.bubble_mem, if1.flush_if, if1.busy,
                   if1.perf_stall_cyc, if1.perf_mul_cyc, r, id, mul, mreq, hit);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic id_lvl;
        rst = 1'b1;
        if0.id_req = 1'b0; if0.ex_mul_start = 1'b0; if0.mem_req = 1'b0; if0.mem_base_hit = 1'b0;
        if1.id_req = 1'b0; if1.ex_mul_start = 1'b0; if1.mem_req = 1'b0; if1.mem_base_hit = 1'b0;
        @(negedge clk);

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(1);

        // MUL then load-use from a clean reset: perf counts 4 stall / 3 mul on u0
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(6);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);

        // All three requests at once, id_req held as a level afterwards
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);

        // RAM conflict, then a data access outside the instruction bank
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Back-to-back: MEM conflict held, then ends on the IDLE re-evaluation cycle
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Reset on the second MUL cycle, new request right after reset drops
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);

        // Randomised traffic
        id_lvl = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 4) == 0) id_lvl = ~id_lvl;
            step(($urandom_range(0, 99) == 0),
                 id_lvl,
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 1) == 1));
        end
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
